// File: rtl/compressed_line_serializer.sv
// compressed_line_serializer
//
// Takes one finished packed line per transaction (compressed line, its bit
// count, the stop flag and the raw fallback line) and streams it out as a
// header beat followed by only the data beats that carry valid bits, MSB
// first. Unused trailing bits of the last data beat are zeroed.
//
// Header beat layout: [BEAT_WIDTH-1] = raw bit, [LEN_WIDTH-1:0] = length,
// everything else zero.
//
// Ports:
//   i_clk          clock, all state on the rising edge
//   i_reset        synchronous reset, active-low
//   i_line_valid   line, length and flag valid this cycle
//   o_line_ready   serializer can accept a line (idle)
//   i_line         packed line, first compressed bit at LINE_WIDTH-1
//   i_line_bits    number of valid compressed bits
//   i_raw_line     uncompressed line, sent when the line is treated as raw
//   i_stop_flag    compression abandoned, send i_raw_line
//   o_beat_valid   o_beat_data / o_beat_last are valid
//   i_beat_ready   sink accepts the current beat
//   o_beat_data    header or data beat
//   o_beat_last    final beat of the current line
//   o_busy         a transaction is in progress
module compressed_line_serializer #(
    parameter int LINE_WIDTH = 128,
    parameter int BEAT_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_line_valid,
    output logic                  o_line_ready,
    input  logic [LINE_WIDTH-1:0] i_line,
    input  logic [LEN_WIDTH-1:0]  i_line_bits,
    input  logic [LINE_WIDTH-1:0] i_raw_line,
    input  logic                  i_stop_flag,
    output logic                  o_beat_valid,
    input  logic                  i_beat_ready,
    output logic [BEAT_WIDTH-1:0] o_beat_data,
    output logic                  o_beat_last,
    output logic                  o_busy
);

    localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_WIDTH = $clog2(NUM_BEATS + 1);
    localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(LINE_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [LINE_WIDTH-1:0] payload_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  raw_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  k_q;
    logic [CNT_WIDTH-1:0]  k_d;

    logic                  cap_raw;
    logic [LEN_WIDTH-1:0]  cap_len;
    logic [LINE_WIDTH-1:0] cap_mask;
    logic [LINE_WIDTH-1:0] cap_payload;
    logic [CNT_WIDTH-1:0]  cap_count;

    logic                  data_last;
    logic [BEAT_WIDTH-1:0] header_beat;
    logic [BEAT_WIDTH-1:0] data_beat;

    // Capture decode. An over-long bit count is a protocol error and is
    // handled exactly like an abandoned compression. The length mask is
    // applied once here so the stored payload already has its trailing
    // bits zeroed; a raw line has length LINE_WIDTH, so its mask is all ones.
    always_comb begin
        cap_raw     = i_stop_flag | (i_line_bits > FULL_LEN);
        cap_len     = cap_raw ? FULL_LEN : i_line_bits;
        cap_mask    = ~({LINE_WIDTH{1'b1}} >> cap_len);
        cap_payload = (cap_raw ? i_raw_line : i_line) & cap_mask;
        cap_count   = CNT_WIDTH'((32'(cap_len) + BEAT_WIDTH - 1) / BEAT_WIDTH);
    end

    // State, beat index and captured line. The capture registers only load
    // in IDLE, so anything the upstream holds on the inputs while busy is
    // ignored until the current line has fully drained.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            payload_q <= '0;
            len_q     <= '0;
            raw_q     <= 1'b0;
            count_q   <= '0;
            k_q       <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (state_q == IDLE && i_line_valid) begin
                payload_q <= cap_payload;
                len_q     <= cap_len;
                raw_q     <= cap_raw;
                count_q   <= cap_count;
            end
        end
    end

    assign data_last = ((k_q + CNT_WIDTH'(1)) == count_q);

    // Next-state logic. Without a handshake every branch keeps state and
    // index, which is what holds the presented beat stable under backpressure.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                k_d = '0;
                if (i_line_valid) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (i_beat_ready) begin
                    k_d     = '0;
                    state_d = (count_q == '0) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (i_beat_ready) begin
                    if (data_last) begin
                        state_d = IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Beat formatting, decoded purely from registered state so no input
    // reaches an output combinationally.
    always_comb begin
        header_beat                 = '0;
        header_beat[BEAT_WIDTH-1]   = raw_q;
        header_beat[LEN_WIDTH-1:0]  = len_q;

        data_beat = '0;
        for (int i = 0; i < NUM_BEATS; i++) begin
            if (k_q == CNT_WIDTH'(i)) begin
                data_beat = payload_q[LINE_WIDTH-1-BEAT_WIDTH*i -: BEAT_WIDTH];
            end
        end
    end

    always_comb begin
        o_line_ready = (state_q == IDLE);
        o_busy       = (state_q != IDLE);
        o_beat_valid = (state_q != IDLE);
        o_beat_data  = '0;
        o_beat_last  = 1'b0;
        unique case (state_q)
            HEADER: begin
                o_beat_data = header_beat;
                o_beat_last = (count_q == '0);
            end
            DATA: begin
                o_beat_data = data_beat;
                o_beat_last = data_last;
            end
            default: begin
                o_beat_data = '0;
                o_beat_last = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_compressed_line_serializer.sv
// tb_compressed_line_serializer
//
// Scoreboard bench for compressed_line_serializer. The driver pushes the
// expected beats of each line into a queue at the moment the line is
// accepted; an independent monitor compares every presented beat against
// the queue head and pops on each handshake.
module tb_compressed_line_serializer;

    localparam int LINE_WIDTH = 128;
    localparam int BEAT_WIDTH = 32;
    localparam int LEN_WIDTH  = 8;

    typedef struct packed {
        logic [BEAT_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    logic                  i_clk = 1'b0;
    logic                  i_reset;
    logic                  i_line_valid;
    logic                  o_line_ready;
    logic [LINE_WIDTH-1:0] i_line;
    logic [LEN_WIDTH-1:0]  i_line_bits;
    logic [LINE_WIDTH-1:0] i_raw_line;
    logic                  i_stop_flag;
    logic                  o_beat_valid;
    logic                  i_beat_ready = 1'b1;
    logic [BEAT_WIDTH-1:0] o_beat_data;
    logic                  o_beat_last;
    logic                  o_busy;

    beat_t exp_q[$];
    beat_t directed_q[$];
    int    total = 0;
    int    bad = 0;
    int    hs_count = 0;
    int    accept_qsize = 0;
    bit    ready_mode = 1'b0;

    compressed_line_serializer #(
        .LINE_WIDTH(LINE_WIDTH),
        .BEAT_WIDTH(BEAT_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_line_valid(i_line_valid),
        .o_line_ready(o_line_ready),
        .i_line      (i_line),
        .i_line_bits (i_line_bits),
        .i_raw_line  (i_raw_line),
        .i_stop_flag (i_stop_flag),
        .o_beat_valid(o_beat_valid),
        .i_beat_ready(i_beat_ready),
        .o_beat_data (o_beat_data),
        .o_beat_last (o_beat_last),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Sink: either always ready or a random ready pattern.
    always @(posedge i_clk) begin
        #1;
        i_beat_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected beat stream straight from the line rules,
    // one output bit at a time.
    function automatic void pushModel(input logic [LINE_WIDTH-1:0] line, input int bits,
                                      input logic [LINE_WIDTH-1:0] raw_line, input bit stop);
        bit                    raw;
        int                    len;
        int                    n;
        logic [LINE_WIDTH-1:0] payload;
        beat_t                 b;
        raw     = stop || (bits > LINE_WIDTH);
        len     = raw ? LINE_WIDTH : bits;
        payload = raw ? raw_line : line;
        n       = (len + BEAT_WIDTH - 1) / BEAT_WIDTH;
        b.data  = '0;
        b.data[BEAT_WIDTH-1] = raw;
        b.data[LEN_WIDTH-1:0] = LEN_WIDTH'(len);
        b.last  = (n == 0);
        exp_q.push_back(b);
        for (int k = 0; k < n; k++) begin
            for (int p = 0; p < BEAT_WIDTH; p++) begin
                int pos;
                pos = BEAT_WIDTH * k + p;
                b.data[BEAT_WIDTH-1-p] = (pos < len) ? payload[LINE_WIDTH-1-pos] : 1'b0;
            end
            b.last = (k == n - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
    endtask

    // Presents a line and holds i_line_valid until the DUT is idle; returns
    // in the cycle after the accepting edge with i_line_valid dropped.
    task automatic applyStimulus(input logic [LINE_WIDTH-1:0] line, input int bits,
                                 input logic [LINE_WIDTH-1:0] raw_line, input bit stop);
        int waited;
        bit accepted;
        i_line       = line;
        i_line_bits  = LEN_WIDTH'(bits);
        i_raw_line   = raw_line;
        i_stop_flag  = stop;
        i_line_valid = 1'b1;
        waited   = 0;
        accepted = 1'b0;
        while (!accepted && waited < 300) begin
            @(negedge i_clk);
            if (o_line_ready === 1'b1) accepted = 1'b1;
            else waited++;
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got no o_line_ready expected accept within 300 cycles");
            i_line_valid = 1'b0;
            directed_q.delete();
            return;
        end
        accept_qsize = exp_q.size();
        if (directed_q.size() > 0) begin
            foreach (directed_q[i]) exp_q.push_back(directed_q[i]);
            directed_q.delete();
        end else begin
            pushModel(line, bits, raw_line, stop);
        end
        @(posedge i_clk);
        #1;
        i_line_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || o_busy !== 1'b0) && waited < 500) begin
            @(negedge i_clk);
            waited++;
        end
        checkOutput("drain_pending_beats", 32'(exp_q.size()), 32'd0);
        nextCycle();
    endtask

    function automatic beat_t mk(input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        return b;
    endfunction

    // Monitor: every presented beat must match the queue head; a handshake
    // retires it. Cycles with reset asserted are not checked.
    always @(negedge i_clk) begin
        if (i_reset === 1'b1 && o_beat_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_beat: got %h expected no beat at %0t", o_beat_data, $time);
            end else begin
                checkOutput("beat_data", o_beat_data, exp_q[0].data);
                checkOutput("beat_last", 32'(o_beat_last), 32'(exp_q[0].last));
                if (i_beat_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    hs_count++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [LINE_WIDTH-1:0] ones;
        logic [LINE_WIDTH-1:0] pattern;
        logic [LINE_WIDTH-1:0] rnd;
        int                    hs_before;
        ones    = '1;
        pattern = 128'h0123456789ABCDEF_0123456789ABCDEF;

        // Reset held for three cycles with random inputs.
        i_reset      = 1'b0;
        i_line_valid = 1'b0;
        i_line       = '0;
        i_line_bits  = '0;
        i_raw_line   = '0;
        i_stop_flag  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk);
            #1;
            i_line_valid = 1'($urandom_range(0, 1));
            i_line       = {$urandom, $urandom, $urandom, $urandom};
            i_line_bits  = 8'($urandom);
            i_stop_flag  = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            checkOutput("reset_beat_valid", 32'(o_beat_valid), 32'd0);
            checkOutput("reset_line_ready", 32'(o_line_ready), 32'd1);
            checkOutput("reset_busy", 32'(o_busy), 32'd0);
            checkOutput("reset_beat_data", o_beat_data, 32'd0);
            checkOutput("reset_beat_last", 32'(o_beat_last), 32'd0);
        end
        nextCycle();
        i_reset      = 1'b1;
        i_line_valid = 1'b0;
        nextCycle();

        // 70 compressed bits: header plus three data beats, back to back.
        $display("[TB] compressed 70 bits");
        directed_q.push_back(mk(32'h0000_0046, 1'b0));
        directed_q.push_back(mk(32'hFFFF_FFFF, 1'b0));
        directed_q.push_back(mk(32'hFFFF_FFFF, 1'b0));
        directed_q.push_back(mk(32'hFC00_0000, 1'b1));
        applyStimulus(ones, 70, '0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge i_clk);
            checkOutput("c70_beat_valid", 32'(o_beat_valid), 32'd1);
            checkOutput("c70_beat_last", 32'(o_beat_last), (c == 4) ? 32'd1 : 32'd0);
        end
        @(negedge i_clk);
        checkOutput("c70_ready_after", 32'(o_line_ready), 32'd1);
        nextCycle();

        // Zero length: only the header, flagged last.
        $display("[TB] zero length");
        directed_q.push_back(mk(32'h0000_0000, 1'b1));
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 0, '0, 1'b0);
        @(negedge i_clk);
        checkOutput("zero_beat_valid", 32'(o_beat_valid), 32'd1);
        checkOutput("zero_beat_last", 32'(o_beat_last), 32'd1);
        @(negedge i_clk);
        checkOutput("zero_ready_after", 32'(o_line_ready), 32'd1);
        checkOutput("zero_busy_after", 32'(o_busy), 32'd0);
        nextCycle();

        // Stop flag and over-long length both send the raw line unmasked.
        $display("[TB] raw paths");
        for (int v = 0; v < 2; v++) begin
            directed_q.push_back(mk(32'h8000_0080, 1'b0));
            directed_q.push_back(mk(32'h0123_4567, 1'b0));
            directed_q.push_back(mk(32'h89AB_CDEF, 1'b0));
            directed_q.push_back(mk(32'h0123_4567, 1'b0));
            directed_q.push_back(mk(32'h89AB_CDEF, 1'b1));
            if (v == 0) applyStimulus({$urandom, $urandom, $urandom, $urandom}, 40, pattern, 1'b1);
            else        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 129, pattern, 1'b0);
        end
        waitDrain();

        // Backpressure: 96-bit line, random ready, header + 3 data handshakes.
        $display("[TB] backpressure");
        ready_mode = 1'b1;
        hs_before  = hs_count;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 96, '0, 1'b0);
        waitDrain();
        checkOutput("bp_handshakes", 32'(hs_count - hs_before), 32'd4);

        // Valid held while busy: second line accepted only after the first drains.
        $display("[TB] held valid while busy");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 128, '0, 1'b0);
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 33, '0, 1'b0);
        checkOutput("held_first_drained", 32'(accept_qsize), 32'd0);
        waitDrain();
        ready_mode = 1'b0;
        nextCycle();

        // Reset during data beat k=1 abandons the line.
        $display("[TB] reset mid-transaction");
        hs_before = 0;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 128, '0, 1'b0);
        nextCycle();
        nextCycle();
        i_reset = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        checkOutput("midreset_busy_before", 32'(o_busy), 32'd1);
        nextCycle();
        i_reset = 1'b1;
        hs_before = hs_count;
        @(negedge i_clk);
        checkOutput("midreset_beat_valid", 32'(o_beat_valid), 32'd0);
        checkOutput("midreset_line_ready", 32'(o_line_ready), 32'd1);
        checkOutput("midreset_busy", 32'(o_busy), 32'd0);
        repeat (8) @(negedge i_clk);
        checkOutput("midreset_no_more_beats", 32'(hs_count - hs_before), 32'd0);
        nextCycle();

        // Randomized lines against the reference model.
        $display("[TB] random lines");
        for (int n = 0; n < 40; n++) begin
            int bits;
            bit stop;
            ready_mode = 1'($urandom_range(0, 1));
            bits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(120, 255))
                                               : int'($urandom_range(0, 128));
            stop = ($urandom_range(0, 4) == 0);
            rnd  = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(rnd, bits, {$urandom, $urandom, $urandom, $urandom}, stop);
        end
        waitDrain();
        ready_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
